// File: rtl/switch_debounce_capture_pkg.sv
// Shared defaults and sizing helpers for the switch debounce/capture block.
package switch_debounce_capture_pkg;

   localparam int unsigned DefaultDataW          = 2;
   localparam int unsigned DefaultDebounceCycles = 100000;

   // One extra bit so the counter can hold DEBOUNCE_CYCLES itself and saturate there.
   function automatic int unsigned debounceCntW(input int unsigned cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/switch_debounce_capture_sync_debounce.sv
// Two-flop synchronizer, candidate/counter debouncer and commit-event generator.
module sync_debounce
   import switch_debounce_capture_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
   parameter int unsigned DATA_W          = DefaultDataW
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] rawSwitch,
   output logic              commitEvent,
   output logic [DATA_W-1:0] commitData
);

   localparam int unsigned     CntW      = debounceCntW(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CommitCnt = CntW'(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] LastCnt   = CntW'(DEBOUNCE_CYCLES - 1);

   logic [DATA_W-1:0] syncMeta;
   logic [DATA_W-1:0] syncOut;
   logic [DATA_W-1:0] candidate;
   logic [DATA_W-1:0] stableVal;
   logic [CntW-1:0]   count;
   logic              commit;

   // Commit on the edge where the candidate completes DEBOUNCE_CYCLES stable cycles.
   assign commit      = (syncOut == candidate) && (count == LastCnt);
   assign commitEvent = commit && (candidate != stableVal);
   assign commitData  = candidate;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         syncMeta  <= '0;
         syncOut   <= '0;
         candidate <= '0;
         stableVal <= '0;
         count     <= '0;
      end else begin
         syncMeta <= rawSwitch;
         syncOut  <= syncMeta;
         if (syncOut != candidate) begin
            candidate <= syncOut;
            count     <= '0;
         end else if (count != CommitCnt) begin
            count <= count + CntW'(1);
         end
         if (commit) begin
            stableVal <= candidate;
         end
      end
   end

endmodule

// File: rtl/switch_debounce_capture.sv
// Debounced switch capture with a two-entry (output + pending) valid/ready buffer.
module switch_debounce_capture
   import switch_debounce_capture_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
   parameter int unsigned DATA_W          = DefaultDataW
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] rawSwitch,
   input  logic              clearOverrun,
   input  logic              ready,
   output logic              outValid,
   output logic [DATA_W-1:0] dataOut,
   output logic              overrun
);

   logic              commitEvent;
   logic [DATA_W-1:0] commitData;

   logic              outValidQ, outValidD;
   logic [DATA_W-1:0] dataOutQ, dataOutD;
   logic              pendValidQ, pendValidD;
   logic [DATA_W-1:0] pendDataQ, pendDataD;
   logic              overrunQ, overrunD;
   logic              xfer;
   logic              setOverrun;

   sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DATA_W         (DATA_W)
   ) uSyncDebounce (
      .clk        (clk),
      .rstn       (rstn),
      .rawSwitch  (rawSwitch),
      .commitEvent(commitEvent),
      .commitData (commitData)
   );

   assign xfer = outValidQ && ready;

   always_comb begin
      outValidD  = outValidQ;
      dataOutD   = dataOutQ;
      pendValidD = pendValidQ;
      pendDataD  = pendDataQ;
      setOverrun = 1'b0;
      if (xfer) begin
         if (pendValidQ) begin
            // Pending advances; a coinciding event refills pending without overrun.
            dataOutD   = pendDataQ;
            pendValidD = commitEvent;
            if (commitEvent) begin
               pendDataD = commitData;
            end
         end else begin
            outValidD = commitEvent;
            if (commitEvent) begin
               dataOutD = commitData;
            end
         end
      end else if (!outValidQ) begin
         if (commitEvent) begin
            outValidD = 1'b1;
            dataOutD  = commitData;
         end
      end else if (commitEvent) begin
         pendDataD  = commitData;
         pendValidD = 1'b1;
         setOverrun = pendValidQ;
      end
      overrunD = setOverrun | (overrunQ & ~clearOverrun);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outValidQ  <= 1'b0;
         dataOutQ   <= '0;
         pendValidQ <= 1'b0;
         pendDataQ  <= '0;
         overrunQ   <= 1'b0;
      end else begin
         outValidQ  <= outValidD;
         dataOutQ   <= dataOutD;
         pendValidQ <= pendValidD;
         pendDataQ  <= pendDataD;
         overrunQ   <= overrunD;
      end
   end

   assign outValid = outValidQ;
   assign dataOut  = dataOutQ;
   assign overrun  = overrunQ;

endmodule
